mxv_stream_top: RTL and testbench
=================================

MXV_STREAM_TOP -- requirements
Module: mxv_stream_top

Interface
REQ-001 SHALL have parameter DW, default 8, signed weight/vector element width.
REQ-002 SHALL have parameter ROWS, default 8, matrix rows (= result elements).
REQ-003 SHALL have parameter COLS, default 8, matrix columns (= vector elements).
REQ-004 SHALL have parameter ROW_W, default 3, row index width; ROW_W >= clog2(ROWS).
REQ-005 SHALL have parameter COL_W, default 3, column index width; COL_W >= clog2(COLS).
REQ-006 SHALL have parameter ACC_W, default 16, signed accumulator/result element width; ACC_W >= 2*DW.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 cfg_valid  input  1  weight write strobe.
REQ-010 cfg_addr  input  ROW_W+COL_W  {row, col}; row in upper ROW_W bits.
REQ-011 cfg_data  input  DW  signed weight value.
REQ-012 cfg_err  output  1  one-cycle pulse: rejected weight write.
REQ-013 x_valid  input  1  input vector offered.
REQ-014 x_ready  output  1  block accepts an input vector.
REQ-015 x_vector_flat  input  COLS*DW  signed vector; element c at bits [c*DW +: DW].
REQ-016 res_valid  output  1  result available.
REQ-017 res_ready  input  1  downstream accepts result.
REQ-018 result_flat  output  ROWS*ACC_W  signed result; element r at bits [r*ACC_W +: ACC_W].
REQ-019 busy  output  1  high in COMPUTE or DONE.
REQ-020 ovf  output  1  sticky overflow flag (see Configuration).

Function
REQ-021 SHALL hold a ROWS x COLS signed weight register file W and compute result[r] = sum over c of W[r][c]*x[c].
REQ-022 SHALL implement FSM states IDLE, COMPUTE, DONE.
REQ-023 IDLE: x_ready=1; on x_valid&&x_ready, capture x_vector_flat, clear all accumulators and column counter to 0, go to COMPUTE.
REQ-024 COMPUTE: each cycle, for all rows in parallel, acc[r] += sign-extended (W[r][col]*x[col]); col increments; after the col==COLS-1 update, go to DONE; lasts exactly COLS cycles.
REQ-025 DONE: res_valid=1, result_flat = accumulators, held stable until res_valid&&res_ready; then go to IDLE, result_flat keeps its value.
REQ-026 x_ready SHALL be 0 in COMPUTE and DONE; no input vector is accepted until the prior result is consumed.
REQ-027 Latency: res_valid first high exactly COLS+1 rising edges after the accepting edge; throughput one vector per COLS+2 cycles with res_ready held high.
REQ-028 Weight write accepted when cfg_valid=1, state is IDLE or DONE, row<ROWS and col<COLS; W updates on that edge.
REQ-029 Weight write in COMPUTE, or with row>=ROWS or col>=COLS, SHALL be dropped and cfg_err SHALL pulse high for the next cycle.
REQ-030 Simultaneous accepted weight write and x handshake in IDLE: the new weight SHALL be used by that computation.
REQ-031 Products SHALL be full 2*DW signed, sign-extended to ACC_W before accumulation.

Reset
REQ-032 On rst_n=0 at a rising edge: state=IDLE, all W entries=0, accumulators=0, captured vector=0, col counter=0, result_flat=0, res_valid=0, cfg_err=0, ovf=0, busy=0; x_ready=1 from the first cycle after reset.
REQ-033 Reset asserted mid-COMPUTE or in DONE SHALL abort the operation with no res_valid pulse.

Configuration
REQ-034 Macro MXV_SAT_EN defined: each accumulation step SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp sets ovf, cleared only by reset.
REQ-035 MXV_SAT_EN undefined: accumulation wraps modulo 2^ACC_W; ovf tied 0.

Verification
REQ-036 W=identity, x=1..8 -> result elements 1..8, res_valid 9 edges after accept.
REQ-037 All W=127, all x=127 -> each result 32767, ovf=1 (MXV_SAT_EN); -2040, ovf=0 (without).
REQ-038 All W=-128, all x=-128 -> 32767 with ovf=1 (MXV_SAT_EN); 0 (without).
REQ-039 res_ready low 5 cycles in DONE, x_valid held high -> result_flat stable, x_ready=0, second vector accepted only after the result handshake.
REQ-040 ROWS=6: cfg write to row 6, and any cfg write during COMPUTE -> W unchanged, cfg_err one-cycle pulse each.
REQ-041 rst_n low 1 cycle at COMPUTE cycle 3 -> IDLE, no res_valid, result_flat=0, W all 0.

Source files
------------

// File: rtl/mxv_stream_top.sv
// Streaming signed matrix-vector multiplier: a ROWS x COLS weight file times one captured vector, one column per cycle.
// Optional feature macro MXV_SAT_EN: saturating accumulation with a sticky ovf flag (default build wraps, ovf = 0).
module mxv_stream_top #(
    parameter int unsigned DW    = 8,
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 8,
    parameter int unsigned ROW_W = 3,
    parameter int unsigned COL_W = 3,
    parameter int unsigned ACC_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    input  logic [ROW_W+COL_W-1:0] cfg_addr,
    input  logic [DW-1:0]          cfg_data,
    output logic                   cfg_err,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [COLS*DW-1:0]     x_vector_flat,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ROWS*ACC_W-1:0]  result_flat,
    output logic                   busy,
    output logic                   ovf
);

    localparam int unsigned AW = ROW_W + COL_W;
    localparam int unsigned PW = 2 * DW;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

`ifdef MXV_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic signed [ACC_W:0]   sum_c;
`endif

    logic [1:0]              state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic                    x_ready_q, x_ready_d;
    logic                    res_valid_q, res_valid_d;
    logic                    busy_q, busy_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    ovf_q, ovf_d;
    logic signed [DW-1:0]    w_q   [ROWS][COLS];
    logic signed [DW-1:0]    x_q   [COLS];
    logic signed [ACC_W-1:0] acc_q [ROWS];
    logic signed [ACC_W-1:0] acc_d [ROWS];
    logic signed [PW-1:0]    prod_c     [ROWS];
    logic signed [ACC_W-1:0] prod_ext_c [ROWS];

    logic [ROW_W-1:0]        cfg_row;
    logic [COL_W-1:0]        cfg_col;
    logic                    cfg_ok;
    logic                    x_fire;

    // Weight writes are legal outside COMPUTE and only inside the populated matrix.
    assign cfg_row = cfg_addr[AW-1:COL_W];
    assign cfg_col = cfg_addr[COL_W-1:0];
    assign cfg_ok  = cfg_valid && (state_q != S_COMPUTE)
                  && ({1'b0, cfg_row} < (ROW_W+1)'(ROWS))
                  && ({1'b0, cfg_col} < (COL_W+1)'(COLS));
    assign x_fire  = x_valid && x_ready_q;

    // Full-precision column products for every row, sign-extended to accumulator width.
    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            prod_c[r]     = PW'(w_q[r][col_q]) * PW'(x_q[col_q]);
            prod_ext_c[r] = ACC_W'(prod_c[r]);
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        ovf_d     = ovf_q;
        acc_d     = acc_q;
`ifdef MXV_SAT_EN
        sum_c     = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (x_fire) begin
                    state_d = S_COMPUTE;
                    col_d   = '0;
                    for (int unsigned r = 0; r < ROWS; r++) acc_d[r] = '0;
                end
            end
            S_COMPUTE: begin
                for (int unsigned r = 0; r < ROWS; r++) begin
`ifdef MXV_SAT_EN
                    sum_c = (ACC_W+1)'(acc_q[r]) + (ACC_W+1)'(prod_ext_c[r]);
                    if (sum_c[ACC_W] != sum_c[ACC_W-1]) begin
                        acc_d[r] = sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
                        ovf_d    = 1'b1;
                    end else begin
                        acc_d[r] = sum_c[ACC_W-1:0];
                    end
`else
                    acc_d[r] = acc_q[r] + prod_ext_c[r];
`endif
                end
                if (col_q == COL_W'(COLS - 1)) begin
                    state_d = S_DONE;
                    col_d   = '0;
                end else begin
                    col_d   = col_q + COL_W'(1);
                end
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        x_ready_d   = (state_d == S_IDLE);
        res_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        cfg_err_d   = cfg_valid && !cfg_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            x_ready_q   <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
            for (int unsigned r = 0; r < ROWS; r++) begin
                acc_q[r] <= '0;
                for (int unsigned c = 0; c < COLS; c++) w_q[r][c] <= '0;
            end
            for (int unsigned c = 0; c < COLS; c++) x_q[c] <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            x_ready_q   <= x_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            cfg_err_q   <= cfg_err_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
            if (cfg_ok) w_q[cfg_row][cfg_col] <= cfg_data;
            if (x_fire) begin
                for (int unsigned c = 0; c < COLS; c++) x_q[c] <= x_vector_flat[c*DW +: DW];
            end
        end
    end

    // Accumulators hold their value after DONE, so they double as the result register.
    for (genvar r = 0; r < ROWS; r++) begin : g_res
        assign result_flat[r*ACC_W +: ACC_W] = acc_q[r];
    end

    assign x_ready   = x_ready_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mxv_stream_top.sv
// Randomized self-checking bench for mxv_stream_top against an arithmetic matrix-vector reference model.
module tb_mxv_stream_top;

    localparam int unsigned DW    = 8;
    localparam int unsigned ROWS  = 6;
    localparam int unsigned COLS  = 8;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned COL_W = 3;
    localparam int unsigned ACC_W = 16;
    localparam int unsigned RW    = ROWS * ACC_W;

    logic                   clk;
    logic                   rst_n;
    logic                   cfg_valid;
    logic [ROW_W+COL_W-1:0] cfg_addr;
    logic [DW-1:0]          cfg_data;
    logic                   cfg_err;
    logic                   x_valid;
    logic                   x_ready;
    logic [COLS*DW-1:0]     x_vector_flat;
    logic                   res_valid;
    logic                   res_ready;
    logic [RW-1:0]          result_flat;
    logic                   busy;
    logic                   ovf;

    int checks   = 0;
    int failures = 0;
    int w_m [ROWS][COLS];
    int x_m [COLS];
    int xb  [COLS];
    bit ovf_m;

    mxv_stream_top #(
        .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .x_valid(x_valid), .x_ready(x_ready), .x_vector_flat(x_vector_flat),
        .res_valid(res_valid), .res_ready(res_ready), .result_flat(result_flat),
        .busy(busy), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COLS*DW-1:0] pack(input int v [COLS]);
        logic [COLS*DW-1:0] f;
        for (int c = 0; c < COLS; c++) f[c*DW +: DW] = DW'(v[c]);
        return f;
    endfunction

    // Reference: plain integer dot products, clamped or wrapped after every step.
    task automatic model_result(output logic [RW-1:0] res);
        longint a;
        logic signed [ACC_W-1:0] t;
        for (int r = 0; r < ROWS; r++) begin
            a = 0;
            for (int c = 0; c < COLS; c++) begin
                a = a + longint'(w_m[r][c]) * longint'(x_m[c]);
`ifdef MXV_SAT_EN
                if (a > (longint'(1) << (ACC_W-1)) - 1) begin
                    a = (longint'(1) << (ACC_W-1)) - 1;
                    ovf_m = 1'b1;
                end else if (a < -(longint'(1) << (ACC_W-1))) begin
                    a = -(longint'(1) << (ACC_W-1));
                    ovf_m = 1'b1;
                end
`else
                t = a[ACC_W-1:0];
                a = t;
`endif
            end
            res[r*ACC_W +: ACC_W] = a[ACC_W-1:0];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; x_valid = 1'b0; res_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) w_m[r][c] = 0;
        ovf_m = 1'b0;
    endtask

    task automatic cfg_write(input int row, input int col, input int val, input bit in_compute);
        bit exp_err;
        exp_err   = in_compute || (row >= int'(ROWS)) || (col >= int'(COLS));
        cfg_valid = 1'b1;
        cfg_addr  = {ROW_W'(row), COL_W'(col)};
        cfg_data  = DW'(val);
        tick();
        cfg_valid = 1'b0;
        check("cfg_err", cfg_err, exp_err);
        if (!exp_err) w_m[row][col] = val;
    endtask

    task automatic start_vec(input bit keep_valid);
        check("x_ready_idle", x_ready, 1'b1);
        x_vector_flat = pack(x_m);
        x_valid = 1'b1;
        tick();
        x_valid = keep_valid;
        check("busy_start", busy, 1'b1);
        check("x_ready_busy", x_ready, 1'b0);
    endtask

    // n0 = rising edges already elapsed since (and including) the accepting edge.
    task automatic wait_done(input int n0, input string tag);
        int n;
        logic [RW-1:0] exp;
        n = n0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, COLS + 1);
        model_result(exp);
        check({tag, "_result"}, result_flat, exp);
        check({tag, "_ovf"}, ovf, ovf_m);
    endtask

    task automatic handshake();
        logic [RW-1:0] held;
        held = result_flat;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("hs_res_valid", res_valid, 1'b0);
        check("hs_x_ready", x_ready, 1'b1);
        check("hs_result_kept", result_flat, held);
    endtask

    task automatic rand_x();
        for (int c = 0; c < COLS; c++) x_m[c] = int'($urandom_range(0, 255)) - 128;
    endtask

    logic [ACC_W-1:0] e16;
    logic [RW-1:0]    exp_a;
    int               n, hits;
    bit               was_ready;

    initial begin
        cfg_addr = '0; cfg_data = '0; x_vector_flat = '0;
        do_reset();
        check("rst_x_ready", x_ready, 1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_result", result_flat, '0);

        // Identity weights, x = 1..8.
        for (int r = 0; r < ROWS; r++) cfg_write(r, r, 1, 1'b0);
        for (int c = 0; c < COLS; c++) x_m[c] = c + 1;
        start_vec(1'b0);
        wait_done(1, "ident");
        for (int r = 0; r < ROWS; r++) begin
            e16 = ACC_W'(r + 1);
            check("ident_elem", result_flat[r*ACC_W +: ACC_W], e16);
        end
        handshake();

        // All +127 and all -128 corner products.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) cfg_write(r, c, k == 0 ? 127 : -128, 1'b0);
            for (int c = 0; c < COLS; c++) x_m[c] = (k == 0) ? 127 : -128;
            start_vec(1'b0);
            wait_done(1, k == 0 ? "max_pos" : "max_neg");
`ifdef MXV_SAT_EN
            e16 = 16'h7FFF;
            check("corner_ovf", ovf, 1'b1);
`else
            e16 = (k == 0) ? ACC_W'(-2040) : '0;
            check("corner_ovf", ovf, 1'b0);
`endif
            check("corner_elem0", result_flat[ACC_W-1:0], e16);
            check("corner_elemN", result_flat[(ROWS-1)*ACC_W +: ACC_W], e16);
            handshake();
        end

        // Backpressure in DONE with x_valid held high and a second vector waiting.
        do_reset();
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) cfg_write(r, c, int'($urandom_range(0, 255)) - 128, 1'b0);
        rand_x();
        for (int c = 0; c < COLS; c++) xb[c] = int'($urandom_range(0, 255)) - 128;
        start_vec(1'b1);
        x_vector_flat = pack(xb);
        wait_done(1, "bp_first");
        model_result(exp_a);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_x_ready", x_ready, 1'b0);
            check("bp_res_valid", res_valid, 1'b1);
            check("bp_result", result_flat, exp_a);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_idle_busy", busy, 1'b0);
        check("bp_idle_x_ready", x_ready, 1'b1);
        for (int c = 0; c < COLS; c++) x_m[c] = xb[c];
        tick();
        x_valid = 1'b0;
        check("bp_second_busy", busy, 1'b1);
        wait_done(1, "bp_second");
        handshake();

        // Throughput with both handshakes held high.
        rand_x();
        x_vector_flat = pack(x_m);
        x_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        n = 0;
        was_ready = 1'b0;
        while (!was_ready && n < 40) begin
            was_ready = x_ready;
            tick();
            n++;
        end
        x_valid = 1'b0;
        check("throughput", n, COLS + 2);
        wait_done(1, "tput_second");
        res_ready = 1'b0;
        handshake();

        // Rejected writes: out-of-range row in IDLE, any write in COMPUTE; write in DONE is taken.
        cfg_write(ROWS, 0, 55, 1'b0);
        tick();
        check("cfg_err_pulse_end", cfg_err, 1'b0);
        rand_x();
        start_vec(1'b0);
        cfg_write(0, 0, 99, 1'b1);
        tick();
        check("cfg_err_compute_end", cfg_err, 1'b0);
        wait_done(3, "cfg_compute");
        cfg_write(1, 2, -77, 1'b0);
        handshake();
        rand_x();
        start_vec(1'b0);
        wait_done(1, "cfg_done_write");
        handshake();

        // Weight write coinciding with the accepting edge is used by that vector.
        rand_x();
        x_vector_flat = pack(x_m);
        x_valid = 1'b1;
        cfg_valid = 1'b1;
        cfg_addr = {ROW_W'(2), COL_W'(5)};
        cfg_data = DW'(-100);
        tick();
        x_valid = 1'b0;
        cfg_valid = 1'b0;
        w_m[2][5] = -100;
        check("simul_cfg_err", cfg_err, 1'b0);
        wait_done(1, "simul");
        handshake();

        // Reset at COMPUTE cycle 3 aborts the operation.
        rand_x();
        start_vec(1'b0);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) w_m[r][c] = 0;
        ovf_m = 1'b0;
        check("abort_x_ready", x_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_result", result_flat, '0);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            if (res_valid) hits++;
            tick();
        end
        check("abort_no_res_valid", hits, 0);
        rand_x();
        start_vec(1'b0);
        wait_done(1, "abort_w_zero");
        handshake();

        // Randomized matrices, with stray out-of-range writes mixed in.
        for (int it = 0; it < 8; it++) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    cfg_write(r, c, ($urandom_range(0, 3) == 0) ? 127 : int'($urandom_range(0, 255)) - 128, 1'b0);
                end
            end
            cfg_write(int'($urandom_range(ROWS, 7)), int'($urandom_range(0, COLS - 1)), 1, 1'b0);
            rand_x();
            start_vec(1'b0);
            wait_done(1, "rand");
            handshake();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
